// File: rtl/dac_serial_tx.sv
// dac_serial_tx: serial DAC transmitter. Takes DATA_W-bit samples over a
// valid/ready handshake, holds one in a single-entry buffer and shifts it
// out as a 16-bit MSB-first frame {2'b00, pd, data} with active-low sync.
// sclk is free-running at clk / (2*CLK_DIV); data changes on sclk rising
// edges so the DAC samples it on falling edges.
// Optional build macro: DAC_PD_CTRL_EN adds pd_mode[1:0], sent as bits 13:12.
module dac_serial_tx #(
   parameter int DATA_W      = 12,
   parameter int CLK_DIV     = 4,
   parameter int GAP_PERIODS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
`ifdef DAC_PD_CTRL_EN
   input  logic [1:0]        pd_mode,
`endif
   output logic              in_ready,
   output logic              sclk,
   output logic              sdo_dac,
   output logic              ssync_dac,
   output logic              busy,
   output logic              frame_done
);

   localparam int FRAME_W = DATA_W + 4;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W   = (GAP_PERIODS > 1) ? $clog2(GAP_PERIODS) : 1;
   localparam int BIT_W   = $clog2(FRAME_W);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_PERIODS - 1);
   localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(FRAME_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick, rise_tick;
   logic                 buf_full;
   logic [FRAME_W-1:0]   buf_word, word_in;
   logic [FRAME_W-1:0]   shreg, shreg_nxt;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
   logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
   logic                 sdo_nxt, ssync_nxt, done_nxt, load;

   // Frame word as it will be shifted: two zero bits, power-down bits, data.
`ifdef DAC_PD_CTRL_EN
   assign word_in = {2'b00, pd_mode, in_data};
`else
   assign word_in = {2'b00, 2'b00, in_data};
`endif

   assign tick      = (div_cnt == DIV_LAST);
   assign rise_tick = tick & ~sclk;
   assign in_ready  = ~buf_full;
   assign busy      = (state != IDLE);

   // Free-running sclk divider; runs in every state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // One-entry holding buffer; a load frees it, a new sample only fills an empty one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_full <= 1'b0;
         buf_word <= '0;
      end else if (load) begin
         buf_full <= 1'b0;
      end else if (in_valid && !buf_full) begin
         buf_full <= 1'b1;
         buf_word <= word_in;
      end
   end

   // Next-state and serial output decode; everything moves only on rise_tick.
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      gap_cnt_nxt = gap_cnt;
      sdo_nxt     = sdo_dac;
      ssync_nxt   = ssync_dac;
      done_nxt    = 1'b0;
      load        = 1'b0;
      case (state)
         IDLE: begin
            if (rise_tick && buf_full) load = 1'b1;
         end
         SHIFT: begin
            if (rise_tick) begin
               if (bit_cnt != '0) begin
                  shreg_nxt   = shreg << 1;
                  sdo_nxt     = shreg[FRAME_W-2];
                  bit_cnt_nxt = bit_cnt - BIT_W'(1);
               end else begin
                  // bit0 was sampled at the previous falling edge: close the frame
                  ssync_nxt   = 1'b1;
                  sdo_nxt     = 1'b0;
                  gap_cnt_nxt = '0;
                  state_nxt   = GAP;
               end
            end
         end
         GAP: begin
            if (rise_tick) begin
               if (gap_cnt == GAP_LAST) begin
                  done_nxt = 1'b1;
                  if (buf_full) load = 1'b1;
                  else          state_nxt = IDLE;
               end else begin
                  gap_cnt_nxt = gap_cnt + GAP_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Frame start shared by IDLE and the end of GAP.
      if (load) begin
         shreg_nxt   = buf_word;
         sdo_nxt     = buf_word[FRAME_W-1];
         ssync_nxt   = 1'b0;
         bit_cnt_nxt = BIT_TOP;
         state_nxt   = SHIFT;
      end
   end

   // State and serial output registers; reset aborts any frame at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         sdo_dac    <= 1'b0;
         ssync_dac  <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         bit_cnt    <= bit_cnt_nxt;
         gap_cnt    <= gap_cnt_nxt;
         sdo_dac    <= sdo_nxt;
         ssync_dac  <= ssync_nxt;
         frame_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb_dac_serial_tx: drives samples through the handshake and decodes the
// serial pins like a DAC would (bits on sclk falling edges while sync low).
module tb_dac_serial_tx;

   localparam int CLK_DIV   = 2;
   localparam int GAP_P     = 1;
   localparam int FRAME_CLK = 32 * CLK_DIV;
   localparam int GAP_CLK   = 2 * CLK_DIV * GAP_P;

   logic        clk, reset, in_valid, in_ready;
   logic [11:0] in_data;
   logic        sclk, sdo_dac, ssync_dac, busy, frame_done;
`ifdef DAC_PD_CTRL_EN
   logic [1:0]  pd_mode;
`endif

   dac_serial_tx #(.DATA_W(12), .CLK_DIV(CLK_DIV), .GAP_PERIODS(GAP_P)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
`ifdef DAC_PD_CTRL_EN
      .pd_mode(pd_mode),
`endif
      .in_ready(in_ready), .sclk(sclk), .sdo_dac(sdo_dac),
      .ssync_dac(ssync_dac), .busy(busy), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      int          bits;
      int          low;
   } frame_t;

   frame_t      got_q[$];
   logic [15:0] exp_q[$];
   int          gap_q[$];
   int          tests = 0;
   int          fails = 0;
   int          done_hi = 0;

   // DAC-side decoder: frames, sync-low length, gaps kept while busy stays high.
   logic [15:0] m_word;
   int          m_bits, m_low, m_high;
   logic        m_prev_sclk, m_prev_ss, m_seen;
   always @(negedge clk) begin
      if (!reset) begin
         m_word = '0; m_bits = 0; m_low = 0; m_high = 0;
         m_prev_sclk = 1'b0; m_prev_ss = 1'b1; m_seen = 1'b0;
      end else begin
         if (frame_done) done_hi++;
         if (!ssync_dac) begin
            if (m_prev_ss && m_seen) gap_q.push_back(m_high);
            m_low++;
            if (m_prev_sclk && !sclk) begin
               m_word = {m_word[14:0], sdo_dac};
               m_bits++;
            end
         end else begin
            if (!m_prev_ss) begin
               got_q.push_back('{word: m_word, bits: m_bits, low: m_low});
               m_word = '0; m_bits = 0; m_low = 0; m_high = 0; m_seen = 1'b1;
            end
            m_high++;
         end
         if (!busy) m_seen = 1'b0;
         m_prev_sclk = sclk;
         m_prev_ss   = ssync_dac;
      end
   end

   // Present one sample (called at a negedge) and hold it until accepted.
   task automatic send(input logic [11:0] d, output int wc, output logic ss_before,
                       output logic ss_exit);
      logic ss_p;
      in_data = d; in_valid = 1'b1; wc = 0; ss_p = ssync_dac;
      while (!in_ready && wc < 1000) begin
         ss_p = ssync_dac;
         @(negedge clk);
         wc++;
      end
      ss_before = ss_p;
      ss_exit   = ssync_dac;
      tests++;
      if (!in_ready) begin
         fails++;
         $display("FAIL send_accept data=%h in_ready=%b required=1 after %0d cycles", d, in_ready, wc);
      end else begin
         @(posedge clk);
`ifdef DAC_PD_CTRL_EN
         exp_q.push_back({2'b00, pd_mode, d});
`else
         exp_q.push_back({4'h0, d});
`endif
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Bounded wait until n frames decoded and the block is idle.
   task automatic wait_idle(input int n);
      int t;
      t = 0;
      while ((got_q.size() < n || busy) && t < 4000) begin
         @(posedge clk); #1; t++;
      end
      tests++;
      if (got_q.size() < n || busy) begin
         fails++;
         $display("FAIL wait_idle frames=%0d required=%0d busy=%b", got_q.size(), n, busy);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = '0;
      #2 reset = 1'b0;
      #1;
      tests++;
      if ({sclk, sdo_dac, ssync_dac, busy, frame_done, in_ready} !== 6'b001001) begin
         fails++;
         $display("FAIL reset_outputs sclk/sdo/ssync/busy/done/rdy=%b required=001001",
                  {sclk, sdo_dac, ssync_dac, busy, frame_done, in_ready});
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_idle();
      int bad_sclk, bad_other;
      logic exp_sclk;
      bad_sclk = 0; bad_other = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         exp_sclk = ((k / CLK_DIV) % 2) == 1;
         if (sclk !== exp_sclk) bad_sclk++;
         if ({ssync_dac, sdo_dac, in_ready, busy, frame_done} !== 5'b10100) bad_other++;
      end
      tests++;
      if (bad_sclk != 0) begin
         fails++; $display("FAIL idle_sclk bad_cycles=%0d required=0", bad_sclk);
      end
      tests++;
      if (bad_other != 0) begin
         fails++; $display("FAIL idle_pins bad_cycles=%0d required=0", bad_other);
      end
      tests++;
      if (got_q.size() != 0) begin
         fails++; $display("FAIL idle_frames got=%0d required=0", got_q.size());
      end
   endtask

   task automatic test_single();
      int wc, lat, d0;
      logic sb, se;
      frame_t f;
      logic [15:0] e;
      d0 = done_hi;
      send(12'hA5C, wc, sb, se);
      lat = 0;
      while (ssync_dac && lat < 50) begin @(negedge clk); lat++; end
      tests++;
      if (lat < 1 || lat > 2 * CLK_DIV) begin
         fails++; $display("FAIL single_latency got=%0d required=1..%0d", lat, 2 * CLK_DIV);
      end
      wait_idle(1);
      if (got_q.size() > 0 && exp_q.size() > 0) begin
         f = got_q.pop_front(); e = exp_q.pop_front();
         tests++;
         if (f.word !== 16'h0A5C || e !== 16'h0A5C) begin
            fails++; $display("FAIL single_word got=%h required=%h", f.word, e);
         end
         tests++;
         if (f.bits != 16 || f.low != FRAME_CLK) begin
            fails++; $display("FAIL single_shape bits=%0d low=%0d required=16/%0d", f.bits, f.low, FRAME_CLK);
         end
      end
      tests++;
      if (done_hi - d0 != 1) begin
         fails++; $display("FAIL single_done pulses=%0d required=1", done_hi - d0);
      end
   endtask

   task automatic test_back_to_back();
      int wc, d0;
      logic sb, se;
      frame_t f;
      logic [15:0] e;
      gap_q.delete(); d0 = done_hi;
      send(12'h001, wc, sb, se);
      send(12'hFFF, wc, sb, se);
      tests++;
      if (wc == 0 || sb !== 1'b1 || se !== 1'b0) begin
         fails++; $display("FAIL b2b_stall wait=%0d sync_before=%b sync_at=%b required >0/1/0", wc, sb, se);
      end
      wait_idle(2);
      for (int i = 0; i < 2; i++) begin
         if (got_q.size() > 0 && exp_q.size() > 0) begin
            f = got_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (f.word !== e || f.bits != 16 || f.low != FRAME_CLK) begin
               fails++; $display("FAIL b2b_frame%0d got=%h bits=%0d low=%0d required=%h", i, f.word, f.bits, f.low, e);
            end
         end
      end
      tests++;
      if (gap_q.size() != 1 || gap_q[0] != GAP_CLK) begin
         fails++; $display("FAIL b2b_gap count=%0d first=%0d required=1/%0d", gap_q.size(),
                           (gap_q.size() > 0) ? gap_q[0] : -1, GAP_CLK);
      end
      tests++;
      if (done_hi - d0 != 2) begin
         fails++; $display("FAIL b2b_done pulses=%0d required=2", done_hi - d0);
      end
   endtask

   task automatic test_three();
      int wc;
      logic sb, se;
      frame_t f;
      logic [15:0] e;
      gap_q.delete();
      send(12'h5A5, wc, sb, se);
      send(12'h0F0, wc, sb, se);
      send(12'h9C3, wc, sb, se);
      tests++;
      if (wc < FRAME_CLK || sb !== 1'b1 || se !== 1'b0) begin
         fails++; $display("FAIL three_stall wait=%0d sync_before=%b sync_at=%b required >=%0d/1/0", wc, sb, se, FRAME_CLK);
      end
      wait_idle(3);
      tests++;
      if (got_q.size() != 3) begin
         fails++; $display("FAIL three_count got=%0d required=3", got_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (got_q.size() > 0 && exp_q.size() > 0) begin
            f = got_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (f.word !== e) begin
               fails++; $display("FAIL three_frame%0d got=%h required=%h", i, f.word, e);
            end
         end
      end
      tests++;
      if (gap_q.size() != 2 || gap_q[0] != GAP_CLK || gap_q[1] != GAP_CLK) begin
         fails++; $display("FAIL three_gaps count=%0d required=2 of %0d clks", gap_q.size(), GAP_CLK);
      end
   endtask

   task automatic test_abort();
      int wc;
      logic sb, se;
      frame_t f;
      send(12'h3C3, wc, sb, se);
      send(12'h777, wc, sb, se);
      repeat (14 * CLK_DIV) @(posedge clk);
      #1;
      tests++;
      if (ssync_dac !== 1'b0 || in_ready !== 1'b0) begin
         fails++; $display("FAIL abort_setup ssync=%b in_ready=%b required=0/0", ssync_dac, in_ready);
      end
      reset = 1'b0;
      #1;
      tests++;
      if ({sclk, sdo_dac, ssync_dac, busy, frame_done, in_ready} !== 6'b001001) begin
         fails++;
         $display("FAIL abort_outputs sclk/sdo/ssync/busy/done/rdy=%b required=001001",
                  {sclk, sdo_dac, ssync_dac, busy, frame_done, in_ready});
      end
      repeat (3) @(negedge clk);
      exp_q.delete(); got_q.delete(); gap_q.delete();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      send(12'h123, wc, sb, se);
      wait_idle(1);
      tests++;
      if (got_q.size() != 1) begin
         fails++; $display("FAIL abort_count got=%0d required=1", got_q.size());
      end
      if (got_q.size() > 0) begin
         f = got_q.pop_front();
         tests++;
         if (f.word !== 16'h0123 || f.bits != 16) begin
            fails++; $display("FAIL abort_frame got=%h bits=%0d required=0123/16", f.word, f.bits);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_random();
      int wc, d0, n, nbad;
      logic sb, se;
      frame_t f;
      logic [15:0] e;
      gap_q.delete(); d0 = done_hi; n = 10; nbad = 0;
      for (int i = 0; i < n; i++) begin
         send(12'($urandom), wc, sb, se);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 120)) @(negedge clk);
      end
      wait_idle(n);
      for (int i = 0; i < n; i++) begin
         if (got_q.size() > 0 && exp_q.size() > 0) begin
            f = got_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (f.word !== e || f.bits != 16 || f.low != FRAME_CLK) begin
               fails++; $display("FAIL random_frame%0d got=%h bits=%0d low=%0d required=%h", i, f.word, f.bits, f.low, e);
            end
         end
      end
      foreach (gap_q[i]) if (gap_q[i] != GAP_CLK) nbad++;
      tests++;
      if (nbad != 0) begin
         fails++; $display("FAIL random_gaps bad=%0d required=0", nbad);
      end
      tests++;
      if (done_hi - d0 != n || exp_q.size() != 0) begin
         fails++; $display("FAIL random_done pulses=%0d left=%0d required=%0d/0", done_hi - d0, exp_q.size(), n);
      end
   endtask

`ifdef DAC_PD_CTRL_EN
   task automatic test_pd();
      int wc;
      logic sb, se;
      frame_t f;
      pd_mode = 2'b11;
      send(12'h800, wc, sb, se);
      pd_mode = 2'b00;
      wait_idle(1);
      if (got_q.size() > 0) begin
         f = got_q.pop_front();
         void'(exp_q.pop_front());
         tests++;
         if (f.word !== 16'h3800) begin
            fails++; $display("FAIL pd_frame got=%h required=3800", f.word);
         end
      end
   endtask
`endif

   initial begin
`ifdef DAC_PD_CTRL_EN
      pd_mode = 2'b00;
`endif
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_three();
      test_abort();
      test_random();
`ifdef DAC_PD_CTRL_EN
      test_pd();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
